fp_add_scheduler: RTL and testbench
===================================

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port a_valid, input, 1 bit: requester A presents an operation.
REQ-004 SHALL have port a_op, input, 26 bits: {sign1, frac1[7:0], exp1[3:0], sign2, frac2[7:0], exp2[3:0]} for requester A.
REQ-005 SHALL have port a_ready, output, 1 bit: A's operation is accepted this cycle.
REQ-006 SHALL have ports b_valid, b_op and b_ready, with the same widths and meanings as the A ports, for requester B.
REQ-007 SHALL have port res_valid, output, 1 bit: the result bus holds a completed result.
REQ-008 SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-009 SHALL have port res_id, output, 1 bit: the owner of the result (0 = A, 1 = B).
REQ-010 SHALL have ports res_sign (output, 1 bit), res_frac (output, 8 bits) and res_exp (output, 4 bits): the result operand.
REQ-011 SHALL have port res_ovf, output, 1 bit: the result saturated.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL treat an operand as value = (-1)^sign * frac * 2^exp, where frac is an unsigned integer with no hidden bit.
REQ-014 SHALL implement FSM states IDLE, ALIGN, ADD, NORM and DONE.
REQ-015 SHALL, in IDLE, grant round-robin: with one valid, grant it; with both valid, grant the requester not served last; the last-served register resets to B, so A wins the first tie.
REQ-016 SHALL drive a_ready and b_ready combinationally, high only in IDLE, at most one at a time, and only towards a requester whose valid is high.
REQ-017 SHALL, on a valid&&ready handshake, capture the op and the requester id, then go IDLE->ALIGN.
REQ-018 SHALL, in ALIGN, pick big = the operand with the larger exp (equal exp: larger frac; full tie: operand 1), shift small.frac right by the exp difference with truncation (difference >= 8 gives 0), take working exp = big.exp, and go ->ADD.
REQ-019 SHALL, in ADD with equal signs, form 9-bit sum = fb + fs with sign = big.sign.
REQ-020 SHALL, in ADD with unequal signs, form |fb - fs| with the sign of the larger aligned frac; a zero result forces sign = 0; go ->NORM.
REQ-021 SHALL, in NORM with sum[8] = 1 and exp < 15, set frac = sum[8:1] and exp += 1 and exit.
REQ-022 SHALL, in NORM with sum[8] = 1 and exp = 15, set frac = 8'hFF, exp = 15 and ovf = 1 and exit.
REQ-023 SHALL, in NORM otherwise, exit when frac[7] = 1, frac = 0 (also forcing exp = 0) or exp = 0; else shift frac left 1, decrement exp and remain in NORM (one shift per cycle).
REQ-024 SHALL, on NORM exit, go ->DONE.
REQ-025 SHALL make NORM last 1 + (number of left shifts) cycles; total latency from the handshake edge to res_valid = 3 + NORM cycles.
REQ-026 SHALL, in DONE, hold res_valid = 1 and all res_* stable until res_ready = 1, then go ->IDLE; no new grant is issued in that same cycle.
REQ-027 SHALL ignore requester valids outside IDLE; requests are never dropped and stay pending until granted.

Reset
REQ-028 SHALL, with rst_n = 0 at any time including mid-operation, immediately force: state IDLE, res_valid 0, res_sign/res_frac/res_exp/res_ovf/res_id 0, busy 0, last-served = B; any in-flight operation is discarded with no result.
REQ-029 SHALL hold a_ready and b_ready at 0 while rst_n = 0.

Verification
REQ-030 SHALL be verified with A = {0,8'h8F,4,1,8'h33,5} -> res {sign 0, frac 8'hA0, exp 2, ovf 0, id 0}, NORM 4 cycles, res_valid at handshake+7.
REQ-031 SHALL be verified with A = {1,52,5,1,53,5} -> res {1, 8'hD2, 4, ovf 0}, and A = {0,3,4,0,2,3} -> res {0, 8'h40, 0} (normalization stopped at exp 0).
REQ-032 SHALL be verified with {0,8'hFF,15,0,8'hFF,15} -> res {0, 8'hFF, 15, ovf 1}, and {0,8'h80,2,0,8'h80,2} -> res {0, 8'h80, 3, ovf 0}, NORM 1 cycle.
REQ-033 SHALL be verified with a_valid and b_valid held continuously with res_ready = 1 -> grants A, B, A, B, res_id alternating 0, 1, 0, 1, and never both readies high.
REQ-034 SHALL be verified with res_ready held 0 for 5 cycles in DONE -> res_* stable, busy 1, no ready asserted; release -> IDLE next cycle.
REQ-035 SHALL be verified with rst_n pulsed low during NORM -> outputs zero immediately, no res_valid afterwards; the next tied request is granted to A.

Source files
------------

// File: rtl/fp_add_scheduler.sv
// Two-requester scheduler in front of a small multi-cycle floating-point adder.
// Operand format: value = (-1)^sign * frac * 2^exp, frac has no hidden bit.
// One operation is in flight at a time; the result is held until consumed.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | round-robin arbitration between A and B, readies live here
//   ALIGN | choose the larger operand, shift the smaller frac right
//   ADD   | signed-magnitude add/subtract into a 9-bit sum
//   NORM  | carry handling / one left shift per cycle until normalized
//   DONE  | result presented, held until the consumer takes it
module fp_add_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [25:0] a_op,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [25:0] b_op,
  output logic        b_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic        res_sign,
  output logic [7:0]  res_frac,
  output logic [3:0]  res_exp,
  output logic        res_ovf,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic        last_q;      // requester served last: 0 = A, 1 = B
  logic [25:0] op_q;
  logic        id_q;
  logic [7:0]  fb_q;
  logic [7:0]  fs_q;
  logic        sb_q;
  logic        ss_q;
  logic [3:0]  exp_q;
  logic [8:0]  sum_q;
  logic        sign_q;
  logic        res_valid_q;
  logic        res_id_q;
  logic        res_sign_q;
  logic [7:0]  res_frac_q;
  logic [3:0]  res_exp_q;
  logic        res_ovf_q;

  logic        s1, s2;
  logic [7:0]  f1, f2;
  logic [3:0]  e1, e2;

  logic        grant_a_d;
  logic        grant_b_d;

  logic [7:0]  fb_d;
  logic [7:0]  fs_d;
  logic        sb_d;
  logic        ss_d;
  logic [3:0]  eb_d;
  logic [3:0]  ediff_d;

  logic [8:0]  sum_d;
  logic        sign_d;

  assign {s1, f1, e1, s2, f2, e2} = op_q;

  // Round-robin: a lone valid wins, a tie goes to whoever was not served last.
  assign grant_a_d = a_valid && (!b_valid || last_q);
  assign grant_b_d = b_valid && (!a_valid || !last_q);

  assign a_ready   = rst_n && (state_q == S_IDLE) && grant_a_d;
  assign b_ready   = rst_n && (state_q == S_IDLE) && grant_b_d;

  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sign  = res_sign_q;
  assign res_frac  = res_frac_q;
  assign res_exp   = res_exp_q;
  assign res_ovf   = res_ovf_q;

  // Alignment: the larger operand (exp first, then frac, operand 1 on a full tie) keeps its exp.
  always_comb begin
    fb_d    = f1;
    sb_d    = s1;
    eb_d    = e1;
    fs_d    = f2;
    ss_d    = s2;
    ediff_d = 4'd0;
    if ((e1 > e2) || ((e1 == e2) && (f1 >= f2))) begin
      ediff_d = e1 - e2;
      fb_d    = f1;
      sb_d    = s1;
      eb_d    = e1;
      fs_d    = f2 >> ediff_d;
      ss_d    = s2;
    end else begin
      ediff_d = e2 - e1;
      fb_d    = f2;
      sb_d    = s2;
      eb_d    = e2;
      fs_d    = f1 >> ediff_d;
      ss_d    = s1;
    end
  end

  // Signed-magnitude add; an exact cancellation yields +0.
  always_comb begin
    sum_d  = 9'd0;
    sign_d = sb_q;
    if (sb_q == ss_q) begin
      sum_d  = {1'b0, fb_q} + {1'b0, fs_q};
      sign_d = sb_q;
    end else if (fb_q > fs_q) begin
      sum_d  = {1'b0, fb_q - fs_q};
      sign_d = sb_q;
    end else if (fs_q > fb_q) begin
      sum_d  = {1'b0, fs_q - fb_q};
      sign_d = ss_q;
    end else begin
      sum_d  = 9'd0;
      sign_d = 1'b0;
    end
  end

  // Sequencer with registered result outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      op_q        <= 26'd0;
      id_q        <= 1'b0;
      fb_q        <= 8'd0;
      fs_q        <= 8'd0;
      sb_q        <= 1'b0;
      ss_q        <= 1'b0;
      exp_q       <= 4'd0;
      sum_q       <= 9'd0;
      sign_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_sign_q  <= 1'b0;
      res_frac_q  <= 8'd0;
      res_exp_q   <= 4'd0;
      res_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_a_d) begin
            op_q    <= a_op;
            id_q    <= 1'b0;
            last_q  <= 1'b0;
            state_q <= S_ALIGN;
          end else if (grant_b_d) begin
            op_q    <= b_op;
            id_q    <= 1'b1;
            last_q  <= 1'b1;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          fb_q    <= fb_d;
          fs_q    <= fs_d;
          sb_q    <= sb_d;
          ss_q    <= ss_d;
          exp_q   <= eb_d;
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          sign_q  <= sign_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (sum_q[8]) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q;
            res_sign_q  <= sign_q;
            state_q     <= S_DONE;
            if (exp_q != 4'd15) begin
              res_frac_q <= sum_q[8:1];
              res_exp_q  <= exp_q + 4'd1;
              res_ovf_q  <= 1'b0;
            end else begin
              res_frac_q <= 8'hFF;
              res_exp_q  <= 4'd15;
              res_ovf_q  <= 1'b1;
            end
          end else if (sum_q[7] || (sum_q[7:0] == 8'd0) || (exp_q == 4'd0)) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q;
            res_sign_q  <= sign_q;
            res_frac_q  <= sum_q[7:0];
            res_exp_q   <= (sum_q[7:0] == 8'd0) ? 4'd0 : exp_q;
            res_ovf_q   <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            sum_q <= {sum_q[7:0], 1'b0};
            exp_q <= exp_q - 4'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: arithmetic reference model plus one per-cycle
// compare process, directed corner vectors and a randomized two-requester run.
module tb_fp_add_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid, b_valid, res_ready;
  logic [25:0] a_op, b_op;
  logic        a_ready, b_ready, res_valid, res_id, res_sign, res_ovf, busy;
  logic [7:0]  res_frac;
  logic [3:0]  res_exp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model / observation state, written only by the compare process
  logic m_busy = 1'b0;
  logic m_last = 1'b1;
  logic m_sign, m_ovf, m_id;
  logic [7:0] m_frac;
  logic [3:0] m_exp;
  int   m_n, m_hs_cyc, m_done_cyc, m_first_rv;
  logic m_seen_rv = 1'b0;
  int   a_hs_cnt = 0;
  int   b_hs_cnt = 0;
  int   res_cnt = 0;
  logic r_sign, r_ovf, r_id;
  logic [7:0] r_frac;
  logic [3:0] r_exp;
  int   r_lat = 0;
  int   id_hist[$];

  fp_add_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_op      (a_op),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_op      (b_op),
    .b_ready   (b_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sign  (res_sign),
    .res_frac  (res_frac),
    .res_exp   (res_exp),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [25:0] mk(input int s1, input int f1, input int e1,
                                     input int s2, input int f2, input int e2);
    logic [25:0] v;
    v = {s1[0], f1[7:0], e1[3:0], s2[0], f2[7:0], e2[3:0]};
    return v;
  endfunction

  // Reference result from plain integer arithmetic on the operand values.
  function automatic void model(input logic [25:0] op, output logic rs, output logic [7:0] rf,
                                output logic [3:0] re, output logic ro, output int n);
    int s1, f1, e1, s2, f2, e2, sb, fb, eb, ss, fs, mag, sg, ex;
    s1 = int'(op[25]); f1 = int'(op[24:17]); e1 = int'(op[16:13]);
    s2 = int'(op[12]); f2 = int'(op[11:4]);  e2 = int'(op[3:0]);
    if (e1 * 256 + f1 >= e2 * 256 + f2) begin
      sb = s1; fb = f1; eb = e1; ss = s2; fs = f2 >> (e1 - e2);
    end else begin
      sb = s2; fb = f2; eb = e2; ss = s1; fs = f1 >> (e2 - e1);
    end
    if (sb == ss) begin mag = fb + fs; sg = sb; end
    else if (fb > fs) begin mag = fb - fs; sg = sb; end
    else if (fs > fb) begin mag = fs - fb; sg = ss; end
    else begin mag = 0; sg = 0; end
    ex = eb; ro = 1'b0; n = 1;
    if (mag > 255) begin
      if (ex < 15) begin mag = mag / 2; ex = ex + 1; end
      else begin mag = 255; ro = 1'b1; end
    end else begin
      while (mag != 0 && mag < 128 && ex > 0) begin
        mag = mag * 2; ex = ex - 1; n = n + 1;
      end
      if (mag == 0) ex = 0;
    end
    rs = sg[0]; rf = mag[7:0]; re = ex[3:0];
  endfunction

  function automatic logic [25:0] rnd_op();
    logic [25:0] v;
    v = 26'($urandom);
    if ($urandom_range(0, 3) == 0) v[16:13] = v[3:0];
    if ($urandom_range(0, 5) == 0) v[24:17] = v[11:4];
    if ($urandom_range(0, 7) == 0) begin v[16:13] = 4'hF; v[3:0] = 4'hF; end
    if ($urandom_range(0, 7) == 0) v[24:17] = 8'h00;
    return v;
  endfunction

  // Per-cycle comparison of every output against the model, plus handshake tracking.
  always @(negedge clk) begin
    logic ear, ebr, erv;
    if (!rst_n) begin
      chk("rst_a_ready", int'(a_ready), 0);
      chk("rst_b_ready", int'(b_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_res_bits", int'({res_id, res_sign, res_frac, res_exp, res_ovf}), 0);
      m_busy = 1'b0;
      m_last = 1'b1;
      m_seen_rv = 1'b0;
    end else begin
      ear = !m_busy && a_valid && (!b_valid || m_last);
      ebr = !m_busy && b_valid && (!a_valid || !m_last);
      erv = m_busy && (cyc >= m_done_cyc);
      chk("a_ready", int'(a_ready), int'(ear));
      chk("b_ready", int'(b_ready), int'(ebr));
      chk("busy", int'(busy), int'(m_busy));
      chk("res_valid", int'(res_valid), int'(erv));
      if (erv) begin
        chk("res_sign", int'(res_sign), int'(m_sign));
        chk("res_frac", int'(res_frac), int'(m_frac));
        chk("res_exp", int'(res_exp), int'(m_exp));
        chk("res_ovf", int'(res_ovf), int'(m_ovf));
        chk("res_id", int'(res_id), int'(m_id));
      end
      if (m_busy && res_valid && !m_seen_rv) begin
        m_seen_rv = 1'b1;
        m_first_rv = cyc;
      end
      if (m_busy && res_valid && res_ready) begin
        m_busy = 1'b0;
        r_sign = res_sign; r_frac = res_frac; r_exp = res_exp; r_ovf = res_ovf; r_id = res_id;
        r_lat = m_first_rv - m_hs_cyc;
        id_hist.push_back(int'(res_id));
        res_cnt++;
      end else if (!m_busy && a_valid && a_ready) begin
        model(a_op, m_sign, m_frac, m_exp, m_ovf, m_n);
        m_id = 1'b0; m_last = 1'b0; m_busy = 1'b1; m_seen_rv = 1'b0;
        m_hs_cyc = cyc; m_done_cyc = cyc + 3 + m_n;
        a_hs_cnt++;
      end else if (!m_busy && b_valid && b_ready) begin
        model(b_op, m_sign, m_frac, m_exp, m_ovf, m_n);
        m_id = 1'b1; m_last = 1'b1; m_busy = 1'b1; m_seen_rv = 1'b0;
        m_hs_cyc = cyc; m_done_cyc = cyc + 3 + m_n;
        b_hs_cnt++;
      end
    end
  end

  task automatic pin(input string name, input logic [25:0] op, input int es, input int ef,
                     input int ee, input int eo, input int en);
    logic ps, po;
    logic [7:0] pf;
    logic [3:0] pe;
    int pn;
    model(op, ps, pf, pe, po, pn);
    chk({name, "_model"}, int'({ps, pf, pe, po}), (es << 13) | (ef << 5) | (ee << 1) | eo);
    chk({name, "_model_norm"}, pn, en);
  endtask

  task automatic run_single(input string name, input logic [25:0] op, input int es, input int ef,
                            input int ee, input int eo, input int elat);
    int n0, r0, t;
    n0 = a_hs_cnt; r0 = res_cnt;
    @(posedge clk); #1;
    a_valid = 1'b1; a_op = op;
    t = 0;
    while (a_hs_cnt == n0 && t < 50) begin @(posedge clk); #1; t++; end
    a_valid = 1'b0;
    chk({name, "_granted"}, int'(a_hs_cnt != n0), 1);
    t = 0;
    while (res_cnt == r0 && t < 60) begin @(posedge clk); #1; t++; end
    chk({name, "_completed"}, int'(res_cnt != r0), 1);
    if (res_cnt != r0) begin
      chk({name, "_sign"}, int'(r_sign), es);
      chk({name, "_frac"}, int'(r_frac), ef);
      chk({name, "_exp"}, int'(r_exp), ee);
      chk({name, "_ovf"}, int'(r_ovf), eo);
      chk({name, "_id"}, int'(r_id), 0);
      chk({name, "_latency"}, r_lat, elat);
    end
  endtask

  initial begin
    int na, nb, r0, h0, t, n0;
    a_valid = 1'b0; b_valid = 1'b0; a_op = '0; b_op = '0; res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    pin("v1", mk(0, 8'h8F, 4, 1, 8'h33, 5), 0, 8'hA0, 2, 0, 4);
    pin("v2", mk(1, 52, 5, 1, 53, 5), 1, 8'hD2, 4, 0, 2);
    pin("v3", mk(0, 3, 4, 0, 2, 3), 0, 8'h40, 0, 0, 5);
    pin("v4", mk(0, 8'hFF, 15, 0, 8'hFF, 15), 0, 8'hFF, 15, 1, 1);
    pin("v5", mk(0, 8'h80, 2, 0, 8'h80, 2), 0, 8'h80, 3, 0, 1);

    run_single("v1", mk(0, 8'h8F, 4, 1, 8'h33, 5), 0, 8'hA0, 2, 0, 7);
    run_single("v2", mk(1, 52, 5, 1, 53, 5), 1, 8'hD2, 4, 0, 5);
    run_single("v3", mk(0, 3, 4, 0, 2, 3), 0, 8'h40, 0, 0, 8);
    run_single("v4", mk(0, 8'hFF, 15, 0, 8'hFF, 15), 0, 8'hFF, 15, 1, 4);
    run_single("v5", mk(0, 8'h80, 2, 0, 8'h80, 2), 0, 8'h80, 3, 0, 4);

    // consumer stalls for five cycles while B waits
    res_ready = 1'b0;
    n0 = a_hs_cnt; nb = b_hs_cnt;
    @(posedge clk); #1;
    a_valid = 1'b1; a_op = mk(0, 8'h80, 2, 0, 8'h80, 2);
    t = 0;
    while (a_hs_cnt == n0 && t < 50) begin @(posedge clk); #1; t++; end
    a_valid = 1'b0;
    b_valid = 1'b1; b_op = mk(0, 8'h10, 1, 0, 8'h01, 0);
    t = 0;
    while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
    repeat (5) begin
      @(negedge clk);
      chk("stall_busy", int'(busy), 1);
      chk("stall_res_valid", int'(res_valid), 1);
      chk("stall_frac", int'(res_frac), 8'h80);
      chk("stall_exp", int'(res_exp), 3);
      chk("stall_b_ready", int'(b_ready), 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_busy", int'(busy), 0);
    chk("release_b_ready", int'(b_ready), 1);
    t = 0;
    while (b_hs_cnt == nb && t < 20) begin @(posedge clk); #1; t++; end
    b_valid = 1'b0;
    r0 = res_cnt;
    t = 0;
    while (res_cnt == r0 && t < 60) begin @(posedge clk); #1; t++; end
    chk("b_after_stall_done", int'(res_cnt != r0), 1);

    // reset while the adder is normalizing, then a held tie on both requesters
    n0 = a_hs_cnt;
    @(posedge clk); #1;
    a_valid = 1'b1; a_op = mk(0, 3, 4, 0, 2, 3);
    t = 0;
    while (a_hs_cnt == n0 && t < 50) begin @(posedge clk); #1; t++; end
    a_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_op = rnd_op(); b_op = rnd_op();
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_res_valid", int'(res_valid), 0);
    chk("midreset_res_bits", int'({res_id, res_sign, res_frac, res_exp, res_ovf}), 0);
    chk("midreset_readies", int'({a_ready, b_ready}), 0);
    @(negedge clk);
    @(posedge clk); #1;
    na = a_hs_cnt; nb = b_hs_cnt; r0 = res_cnt; h0 = id_hist.size();
    rst_n = 1'b1;
    #1;
    chk("post_reset_tie_a", int'(a_ready), 1);
    chk("post_reset_tie_b", int'(b_ready), 0);
    t = 0;
    while (res_cnt - r0 < 4 && t < 200) begin
      @(posedge clk); #1; t++;
      if (a_hs_cnt != na) begin na = a_hs_cnt; a_op = rnd_op(); end
      if (b_hs_cnt != nb) begin nb = b_hs_cnt; b_op = rnd_op(); end
    end
    chk("alternation_results", res_cnt - r0, 4);
    if (id_hist.size() >= h0 + 4) begin
      for (int k = 0; k < 4; k++) chk("alternation_id", id_hist[h0 + k], k % 2);
    end

    // randomized traffic with random consumer back-pressure
    na = a_hs_cnt; nb = b_hs_cnt;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (a_hs_cnt != na) begin
        na = a_hs_cnt; a_valid = ($urandom_range(0, 1) == 1); a_op = rnd_op();
      end else if (!a_valid) begin
        a_valid = ($urandom_range(0, 2) == 0); a_op = rnd_op();
      end
      if (b_hs_cnt != nb) begin
        nb = b_hs_cnt; b_valid = ($urandom_range(0, 1) == 1); b_op = rnd_op();
      end else if (!b_valid) begin
        b_valid = ($urandom_range(0, 2) == 0); b_op = rnd_op();
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b1;
    t = 0;
    while ((busy || a_hs_cnt != na || b_hs_cnt != nb) && t < 60) begin
      na = a_hs_cnt; nb = b_hs_cnt;
      @(posedge clk); #1; t++;
    end
    chk("drain_idle", int'(busy), 0);
    chk("random_results_seen", int'(res_cnt > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
